udp_rx_parser_w: RTL

Parametrised GMII UDP receive parser, next generation of the current single-width receive block. Consumes a raw GMII byte stream, validates preamble/SFD, Ethernet, IPv4 and UDP headers with exact filtering, and packs the payload into DATA_W-bit words with a byte-keep mask. It sits between the GMII RX interface and the payload DMA/FIFO, and adds:
- real SFD check
- IHL-aware option skipping
- protocol and port filtering
- length sanity checks
- abort reporting

---
 rtl/udp_rx_parser_w.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/udp_rx_parser_w.sv
// GMII UDP receive parser: validates preamble/SFD, Ethernet, IPv4 and UDP headers and
// packs the payload into DATA_W-bit words, first received byte in the MSBs.
module udp_rx_parser_w #(
    parameter int          DATA_W         = 32,
    parameter logic [47:0] BOARD_MAC      = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP       = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter bit          PORT_FILTER_EN = 1'b0,
    parameter logic [15:0] BOARD_PORT     = 16'd1234
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                gmii_rx_dv,
    input  logic [7:0]          gmii_rxd,
    output logic                rec_en,
    output logic [DATA_W-1:0]   rec_data,
    output logic [DATA_W/8-1:0] rec_keep,
    output logic                rec_last,
    output logic                rec_pkt_done,
    output logic [15:0]         rec_byte_num,
    output logic [31:0]         rec_src_ip,
    output logic [15:0]         rec_src_port,
    output logic                drop_pulse,
    output logic [15:0]         drop_cnt
);
    localparam int NB = DATA_W / 8;
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA, RX_END
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           hcnt_q, hcnt_d;
    logic [39:0]          sh_q, sh_d;
    logic [3:0]           ihl_q, ihl_d;
    logic [15:0]          tot_len_q, tot_len_d;
    logic [15:0]          udp_len_q, udp_len_d;
    logic [15:0]          sport_q, sport_d;
    logic [15:0]          dport_q, dport_d;
    logic [31:0]          src_ip_q, src_ip_d;
    logic [15:0]          pay_len_q, pay_len_d;
    logic [15:0]          pcnt_q, pcnt_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [NB-1:0][7:0]   word_q, word_d, wnext;

    logic                 rec_en_q, rec_en_d;
    logic [DATA_W-1:0]    rec_data_q, rec_data_d;
    logic [NB-1:0]        rec_keep_q, rec_keep_d;
    logic                 rec_last_q, rec_last_d;
    logic                 rec_pkt_done_q, rec_pkt_done_d;
    logic [15:0]          rec_byte_num_q, rec_byte_num_d;
    logic [31:0]          rec_src_ip_q, rec_src_ip_d;
    logic [15:0]          rec_src_port_q, rec_src_port_d;
    logic                 drop_pulse_q, drop_pulse_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    // Current byte appended to the last five received bytes: multi-byte fields end here.
    logic [47:0] cur;
    logic [5:0]  hdr_len;
    logic        ip_last, pay_last, lane_full, len_ok, port_ok, in_frame, abort;
    logic        rej, stage_done;

    assign cur       = {sh_q, gmii_rxd};
    assign hdr_len   = {ihl_q, 2'b00};
    assign ip_last   = (hcnt_q == hdr_len - 6'd1);
    assign pay_last  = (pcnt_q == pay_len_q - 16'd1);
    assign lane_full = (lane_q == LW'(NB - 1));
    // Sum instead of difference so a short IP total length cannot wrap.
    assign len_ok    = (udp_len_q >= 16'd8) &&
                       (({1'b0, udp_len_q} + {11'd0, hdr_len}) <= {1'b0, tot_len_q});
    assign port_ok   = !PORT_FILTER_EN || (dport_q == BOARD_PORT);
    assign in_frame  = (state_q != IDLE) && (state_q != RX_END);
    assign abort     = in_frame && !gmii_rx_dv;

    always_comb begin
        rej        = 1'b0;
        stage_done = 1'b0;
        case (state_q)
            PREAMBLE: begin
                stage_done = (hcnt_q == 6'd6);
                rej        = stage_done ? (gmii_rxd != 8'hD5) : (gmii_rxd != 8'h55);
            end
            ETH_HEAD: begin
                stage_done = (hcnt_q == 6'd13);
                if (hcnt_q == 6'd5) rej = (cur != BOARD_MAC) && (cur != '1);
                if (stage_done)     rej = (cur[15:0] != 16'h0800);
            end
            IP_HEAD: begin
                stage_done = ip_last;
                if (hcnt_q == 6'd0)  rej = (gmii_rxd[7:4] != 4'd4) || (gmii_rxd[3:0] < 4'd5);
                if (hcnt_q == 6'd9)  rej = (gmii_rxd != 8'd17);
                if (hcnt_q == 6'd19) rej = (cur[31:0] != BOARD_IP) && (cur[31:0] != '1);
            end
            UDP_HEAD: begin
                stage_done = (hcnt_q == 6'd7);
                rej        = stage_done && !(len_ok && port_ok);
            end
            default: ;
        endcase
        rej = rej && gmii_rx_dv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            hcnt_q         <= '0;
            sh_q           <= '0;
            ihl_q          <= '0;
            tot_len_q      <= '0;
            udp_len_q      <= '0;
            sport_q        <= '0;
            dport_q        <= '0;
            src_ip_q       <= '0;
            pay_len_q      <= '0;
            pcnt_q         <= '0;
            lane_q         <= '0;
            word_q         <= '0;
            rec_en_q       <= 1'b0;
            rec_data_q     <= '0;
            rec_keep_q     <= '0;
            rec_last_q     <= 1'b0;
            rec_pkt_done_q <= 1'b0;
            rec_byte_num_q <= '0;
            rec_src_ip_q   <= '0;
            rec_src_port_q <= '0;
            drop_pulse_q   <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            hcnt_q         <= hcnt_d;
            sh_q           <= sh_d;
            ihl_q          <= ihl_d;
            tot_len_q      <= tot_len_d;
            udp_len_q      <= udp_len_d;
            sport_q        <= sport_d;
            dport_q        <= dport_d;
            src_ip_q       <= src_ip_d;
            pay_len_q      <= pay_len_d;
            pcnt_q         <= pcnt_d;
            lane_q         <= lane_d;
            word_q         <= word_d;
            rec_en_q       <= rec_en_d;
            rec_data_q     <= rec_data_d;
            rec_keep_q     <= rec_keep_d;
            rec_last_q     <= rec_last_d;
            rec_pkt_done_q <= rec_pkt_done_d;
            rec_byte_num_q <= rec_byte_num_d;
            rec_src_ip_q   <= rec_src_ip_d;
            rec_src_port_q <= rec_src_port_d;
            drop_pulse_q   <= drop_pulse_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (gmii_rx_dv && gmii_rxd == 8'h55) state_d = PREAMBLE;
            PREAMBLE: if (stage_done) state_d = ETH_HEAD;
            ETH_HEAD: if (stage_done) state_d = IP_HEAD;
            IP_HEAD:  if (stage_done) state_d = UDP_HEAD;
            UDP_HEAD: if (stage_done) state_d = (udp_len_q == 16'd8) ? RX_END : RX_DATA;
            RX_DATA:  if (pay_last) state_d = RX_END;
            RX_END:   if (!gmii_rx_dv) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (rej)   state_d = RX_END;
        if (abort) state_d = IDLE;
    end

    always_comb begin
        hcnt_d         = hcnt_q;
        sh_d           = sh_q;
        ihl_d          = ihl_q;
        tot_len_d      = tot_len_q;
        udp_len_d      = udp_len_q;
        sport_d        = sport_q;
        dport_d        = dport_q;
        src_ip_d       = src_ip_q;
        pay_len_d      = pay_len_q;
        pcnt_d         = pcnt_q;
        lane_d         = lane_q;
        word_d         = word_q;
        rec_en_d       = 1'b0;
        rec_data_d     = rec_data_q;
        rec_keep_d     = rec_keep_q;
        rec_last_d     = 1'b0;
        rec_pkt_done_d = 1'b0;
        rec_byte_num_d = rec_byte_num_q;
        rec_src_ip_d   = rec_src_ip_q;
        rec_src_port_d = rec_src_port_q;
        drop_pulse_d   = 1'b0;
        drop_cnt_d     = drop_cnt_q;

        // A new word starts from zero so unfilled lanes of a partial word read 0.
        wnext = (lane_q == '0) ? '0 : word_q;
        for (int i = 0; i < NB; i++)
            if (lane_q == LW'(i)) wnext[NB-1-i] = gmii_rxd;

        if (gmii_rx_dv) sh_d = cur[39:0];
        if (state_q == IDLE)  hcnt_d = '0;
        else if (gmii_rx_dv)  hcnt_d = stage_done ? 6'd0 : hcnt_q + 6'd1;

        if (gmii_rx_dv) begin
            case (state_q)
                IP_HEAD: begin
                    if (hcnt_q == 6'd0)  ihl_d     = gmii_rxd[3:0];
                    if (hcnt_q == 6'd3)  tot_len_d = cur[15:0];
                    if (hcnt_q == 6'd15) src_ip_d  = cur[31:0];
                end
                UDP_HEAD: begin
                    if (hcnt_q == 6'd1) sport_d   = cur[15:0];
                    if (hcnt_q == 6'd3) dport_d   = cur[15:0];
                    if (hcnt_q == 6'd5) udp_len_d = cur[15:0];
                    if (stage_done) begin
                        pay_len_d = udp_len_q - 16'd8;
                        pcnt_d    = '0;
                        lane_d    = '0;
                        if (!rej && udp_len_q == 16'd8) begin
                            rec_pkt_done_d = 1'b1;
                            rec_byte_num_d = '0;
                            rec_src_ip_d   = src_ip_q;
                            rec_src_port_d = sport_q;
                        end
                    end
                end
                RX_DATA: begin
                    word_d = wnext;
                    pcnt_d = pcnt_q + 16'd1;
                    lane_d = lane_full ? '0 : lane_q + 1'b1;
                    if (lane_full || pay_last) begin
                        rec_en_d   = 1'b1;
                        rec_data_d = wnext;
                        for (int i = 0; i < NB; i++)
                            rec_keep_d[NB-1-i] = (LW'(i) <= lane_q);
                    end
                    if (pay_last) begin
                        rec_last_d     = 1'b1;
                        rec_pkt_done_d = 1'b1;
                        rec_byte_num_d = pay_len_q;
                        rec_src_ip_d   = src_ip_q;
                        rec_src_port_d = sport_q;
                    end
                end
                default: ;
            endcase
        end

        if (rej || abort) begin
            drop_pulse_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    assign rec_en       = rec_en_q;
    assign rec_data     = rec_data_q;
    assign rec_keep     = rec_keep_q;
    assign rec_last     = rec_last_q;
    assign rec_pkt_done = rec_pkt_done_q;
    assign rec_byte_num = rec_byte_num_q;
    assign rec_src_ip   = rec_src_ip_q;
    assign rec_src_port = rec_src_port_q;
    assign drop_pulse   = drop_pulse_q;
    assign drop_cnt     = drop_cnt_q;

endmodule
